// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state type, default sizes and one-hot decode for the Wishbone arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN, ABORT} arb_state_t;

    localparam int DEF_NM = 2;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        onehot_idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) onehot_idx = 3'(i);
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester after the last winner
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NM = DEF_NM
) (
    input  logic [NM-1:0] req,
    input  logic [NM-1:0] last,
    output logic [NM-1:0] win
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        int            base;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        base  = int'(onehot_idx(8'(last)));
        for (int k = 1; k <= NM; k++) begin
            idx = IW'((base + k) % NM);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin Wishbone arbiter, NM masters onto one slave bus.
// Optional stalled-strobe watchdog enabled with `define WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NM      = DEF_NM,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_cyc,
    input  logic [NM-1:0]    m_stb,
    input  logic [NM-1:0]    m_we,
    input  logic [NM*AW-1:0] m_adr,
    input  logic [NM*DW-1:0] m_wdata,
    output logic [DW-1:0]    m_rdata,
    output logic [NM-1:0]    m_ack,
    output logic [NM-1:0]    m_err,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [AW-1:0]    s_adr,
    output logic [DW-1:0]    s_wdata,
    input  logic [DW-1:0]    s_rdata,
    input  logic             s_ack,
    output logic [NM-1:0]    grant
);

    arb_state_t    state;
    logic [NM-1:0] last;
    logic [NM-1:0] win;
    logic          own_cyc, own_stb, own_we, owning, hit;

    rr_pick #(.NM(NM)) u_pick (.req(m_cyc), .last(last), .win(win));

    // AND-OR mux on the one-hot grant: everything reads 0 while idle
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        s_adr   = '0;
        s_wdata = '0;
        for (int i = 0; i < NM; i++) begin
            if (grant[i]) begin
                own_cyc = own_cyc | m_cyc[i];
                own_stb = own_stb | m_stb[i];
                own_we  = own_we  | m_we[i];
                s_adr   = s_adr   | m_adr[i*AW +: AW];
                s_wdata = s_wdata | m_wdata[i*DW +: DW];
            end
        end
    end

    assign owning  = (state == OWN);
    assign s_cyc   = owning & own_cyc;
    assign s_stb   = owning & own_stb;
    assign s_we    = own_we;
    assign m_rdata = s_rdata;
    assign m_ack   = owning ? (grant & m_cyc & m_stb & {NM{s_ack}}) : '0;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          stall;

    assign stall = owning & own_cyc & own_stb & ~s_ack;
    assign hit   = stall && (cnt == CW'(TIMEOUT - 1));
    assign m_err = hit ? grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (stall && !hit) ? cnt + 1'b1 : '0;
    end
`else
    logic unused_cfg;
    assign unused_cfg = TIMEOUT[0];
    assign hit        = 1'b0;
    assign m_err      = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= {1'b1, {(NM-1){1'b0}}};
        end else begin
            case (state)
                IDLE: if (|m_cyc) begin
                    state <= OWN;
                    grant <= win;
                    last  <= win;
                end
                OWN: if (!own_cyc) begin
                    state <= IDLE;
                    grant <= '0;
                end else if (hit) begin
                    state <= ABORT;
                end
                default: if (!own_cyc) begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed self-checking bench for wb_bus_arbiter with two masters
module tb_wb_bus_arbiter;

    localparam int NM = 2, AW = 32, DW = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NM-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [NM*AW-1:0] m_adr = '0;
    logic [NM*DW-1:0] m_wdata = '0;
    logic [DW-1:0]    m_rdata, s_rdata = '0;
    logic [NM-1:0]    m_ack, m_err, grant;
    logic             s_cyc, s_stb, s_we, s_ack = 1'b0;
    logic [AW-1:0]    s_adr;
    logic [DW-1:0]    s_wdata;

    int total = 0;
    int bad   = 0;

    wb_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_grant", 64'(grant), 64'h0);
        check("reset_s_cyc", 64'(s_cyc), 64'h0);
        check("reset_m_ack", 64'(m_ack), 64'h0);
        check("reset_m_err", 64'(m_err), 64'h0);

        // master 0 writes 0xA5 to 0x10
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[0 +: AW] = 32'h10; m_wdata[0 +: DW] = 32'hA5;
        #1;
        check("wr_grant_pre", 64'(grant), 64'h0);
        check("wr_s_cyc_pre", 64'(s_cyc), 64'h0);
        tick();
        check("wr_grant", 64'(grant), 64'h1);
        check("wr_s_cyc", 64'(s_cyc), 64'h1);
        check("wr_s_we", 64'(s_we), 64'h1);
        check("wr_s_adr", 64'(s_adr), 64'h10);
        check("wr_s_wdata", 64'(s_wdata), 64'hA5);
        check("wr_no_ack_yet", 64'(m_ack), 64'h0);
        tick();
        s_ack = 1'b1;
        #1;
        check("wr_ack", 64'(m_ack), 64'h1);
        tick();
        s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
        #1;
        check("wr_drop_s_cyc", 64'(s_cyc), 64'h0);
        tick();
        check("wr_release", 64'(grant), 64'h0);

        // simultaneous requests after a fresh reset
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        check("rr_first_0", 64'(grant), 64'h1);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        check("rr_dead_cycle", 64'(grant), 64'h0);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        check("rr_then_1", 64'(grant), 64'h2);
        check("rr_s_cyc_1", 64'(s_cyc), 64'h1);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();
        check("rr_dead_cycle2", 64'(grant), 64'h0);
        tick();
        check("rr_back_to_0", 64'(grant), 64'h1);
        m_cyc = '0; m_stb = '0;
        tick();
        check("rr_idle", 64'(grant), 64'h0);

        // master 0 burst of three reads while master 1 waits
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        check("burst_grant", 64'(grant), 64'h1);
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        s_ack = 1'b1; s_rdata = 32'h1;
        #1;
        check("burst_ack1", 64'(m_ack), 64'h1);
        check("burst_data1", 64'(m_rdata), 64'h1);
        tick();
        s_rdata = 32'h2;
        #1;
        check("burst_ack2", 64'(m_ack), 64'h1);
        check("burst_data2", 64'(m_rdata), 64'h2);
        tick();
        s_rdata = 32'h3;
        #1;
        check("burst_ack3", 64'(m_ack), 64'h1);
        check("burst_data3", 64'(m_rdata), 64'h3);
        tick();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #1;
        check("burst_end_ack", 64'(m_ack), 64'h0);
        tick();
        s_ack = 1'b1;
        #1;
        check("burst_idle_no_ack", 64'(m_ack), 64'h0);
        tick();
        check("burst_m1_grant", 64'(grant), 64'h2);
        check("burst_m1_ack", 64'(m_ack), 64'h2);
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;
        tick();
        check("burst_idle", 64'(grant), 64'h0);

        // owner drops with strobe pending, slave acks late
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        check("late_grant", 64'(grant), 64'h1);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #1;
        check("late_no_ack_drop", 64'(m_ack), 64'h0);
        tick();
        s_ack = 1'b1;
        #1;
        check("late_ack_blocked", 64'(m_ack), 64'h0);
        check("late_s_cyc", 64'(s_cyc), 64'h0);
        s_ack = 1'b0;
        tick();

        // asynchronous reset in the middle of a burst
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        check("arst_grant", 64'(grant), 64'h2);
        s_ack = 1'b1;
        #1;
        check("arst_ack_before", 64'(m_ack), 64'h2);
        rst = 1'b1;
        #1;
        check("arst_s_cyc", 64'(s_cyc), 64'h0);
        check("arst_grant_0", 64'(grant), 64'h0);
        check("arst_m_ack", 64'(m_ack), 64'h0);
        s_ack = 1'b0;
        #1;
        rst = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11;
        tick();
        check("arst_first_0", 64'(grant), 64'h1);
        m_cyc = '0; m_stb = '0;
        tick();
        tick();

        // stalled strobe on master 1, slave never acks
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        check("wd_grant", 64'(grant), 64'h2);
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            check("wd_no_err_early", 64'(m_err), 64'h0);
            tick();
        end
        check("wd_err_pulse", 64'(m_err), 64'h2);
        check("wd_s_cyc_at_err", 64'(s_cyc), 64'h1);
        tick();
        check("wd_s_cyc_abort", 64'(s_cyc), 64'h0);
        check("wd_s_stb_abort", 64'(s_stb), 64'h0);
        check("wd_err_single", 64'(m_err), 64'h0);
        check("wd_grant_held", 64'(grant), 64'h2);
`else
        for (int i = 1; i < 11; i++) begin
            check("stall_no_err", 64'(m_err), 64'h0);
            tick();
        end
        check("stall_s_cyc_held", 64'(s_cyc), 64'h1);
        check("stall_grant_held", 64'(grant), 64'h2);
`endif
        m_cyc = '0; m_stb = '0;
        tick();
        check("wd_release", 64'(grant), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
